// File: rtl/stopwatch_multi.sv
// Multi-digit MM:SS.hh stopwatch with debounced start/pause and lap/clear
// buttons, lap-freeze display, sticky overflow and registered 7-segment outputs.
module stopwatch_multi #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_50Mhz,
    input  logic                    reset,
    input  logic                    start_pause,
    input  logic                    lap_clear,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    running,
    output logic                    lap_hold,
    output logic                    overflow
);

    localparam int unsigned CLK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HEX_W   = 7 * NUM_DIGITS;

    localparam logic [6:0]       SEG_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
    localparam logic [HEX_W-1:0] HEX_RST  = {NUM_DIGITS{SEG_ZERO}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    // Segment pattern for one BCD digit, in output polarity
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Largest value of a digit: tens-of-seconds and tens-of-minutes are base 6
    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    // ---------------- button path (bit 0 = start_pause, bit 1 = lap_clear)
    logic [1:0]           btn_raw;
    logic [1:0]           meta_q, meta_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           deb_q, deb_d;
    logic [1:0]           pulse_q, pulse_d;
    logic [1:0][DB_W-1:0] dbc_q, dbc_d;

    assign btn_raw = {lap_clear, start_pause};

    // Synchronise, debounce and detect the debounced press edge
    always_comb begin
        meta_d  = btn_raw;
        sync_d  = meta_q;
        deb_d   = deb_q;
        dbc_d   = '0;
        pulse_d = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            if (sync_q[b] != deb_q[b]) begin
                if (dbc_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[b] = sync_q[b];
                end else begin
                    dbc_d[b] = dbc_q[b] + DB_W'(1);
                end
            end
            pulse_d[b] = deb_q[b] & ~deb_d[b];
        end
    end

    // Button path registers; released buttons read as 1
    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) begin
            meta_q  <= 2'b11;
            sync_q  <= 2'b11;
            deb_q   <= 2'b11;
            dbc_q   <= '0;
            pulse_q <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            dbc_q   <= dbc_d;
            pulse_q <= pulse_d;
        end
    end

    logic sp_c, lc_c;
    assign sp_c = pulse_q[0];
    assign lc_c = pulse_q[1] & ~pulse_q[0];

    // ---------------- control FSM
    state_e state_q, state_d;
    logic   lap_hold_q, lap_hold_d;
    logic   running_q, running_d;
    logic   clear_c;

    // Next state, lap toggle and clear request from the press pulses
    always_comb begin
        state_d    = state_q;
        lap_hold_d = lap_hold_q;
        clear_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sp_c)      state_d = S_RUN;
                else if (lc_c) clear_c = 1'b1;
            end
            S_RUN: begin
                if (sp_c)      state_d    = S_PAUSE;
                else if (lc_c) lap_hold_d = ~lap_hold_q;
            end
            S_PAUSE: begin
                if (sp_c) begin
                    state_d = S_RUN;
                end else if (lc_c) begin
                    clear_c = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_c) lap_hold_d = 1'b0;
        running_d = (state_d == S_RUN);
    end

    // ---------------- time base, digit counter and display
    logic [PS_W-1:0]            presc_q, presc_d;
    logic [NUM_DIGITS-1:0][3:0] count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [HEX_W-1:0]           hex_q, hex_d;
    logic                       tick_c;

    assign tick_c = (state_q == S_RUN) && (presc_q == PS_W'(CLK_DIV - 1));

    // Prescaler, ripple-carry digit chain, overflow and lap-aware display load
    always_comb begin
        logic carry;
        presc_d = presc_q;
        if (state_q == S_RUN) begin
            presc_d = tick_c ? '0 : presc_q + PS_W'(1);
        end

        count_d = count_q;
        carry   = tick_c;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[i] == digit_max(i)) begin
                    count_d[i] = 4'd0;
                end else begin
                    count_d[i] = count_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        overflow_d = overflow_q | carry;

        hex_d = hex_q;
        if (!lap_hold_q) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                hex_d[7*i +: 7] = seg_decode(count_q[i]);
            end
        end

        if (clear_c) begin
            presc_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lap_hold_q <= 1'b0;
            running_q  <= 1'b0;
            presc_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hex_q      <= HEX_RST;
        end else begin
            state_q    <= state_d;
            lap_hold_q <= lap_hold_d;
            running_q  <= running_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            hex_q      <= hex_d;
        end
    end

    assign hex      = hex_q;
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_multi.sv
// Bench for stopwatch_multi: integer-time reference model checked every cycle,
// plus hand-computed display/flag values at key points of each scenario.
module tb_stopwatch_multi;

    localparam int unsigned CLK_HZ  = 100;
    localparam int unsigned TICK_HZ = 10;
    localparam int unsigned NDIG    = 4;
    localparam int unsigned DEB     = 2;
    localparam int          CLK_DIV = 10;
    localparam int          MODULUS = 6000;   // 4 digits: 00.00 .. 59.99

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        sp_n  = 1'b1;
    logic        lc_n  = 1'b1;
    logic [27:0] hex;
    logic        running, lap_hold, overflow;

    int errors = 0;
    int checks = 0;

    stopwatch_multi #(
        .CLK_HZ         (CLK_HZ),
        .TICK_HZ        (TICK_HZ),
        .NUM_DIGITS     (NDIG),
        .DEBOUNCE_CYCLES(DEB),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_50Mhz  (clk),
        .reset      (rst_n),
        .start_pause(sp_n),
        .lap_clear  (lc_n),
        .hex        (hex),
        .running    (running),
        .lap_hold   (lap_hold),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: elapsed time as one integer
    int m_mode  = 0;   // 0 idle, 1 run, 2 pause
    int m_presc = 0;
    int m_count = 0;
    int m_disp  = 0;
    bit m_lap   = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_deb   [2];
    bit m_pulse [2];
    bit hist    [2][DEB+2];   // hist[b][j]: raw button level sampled j edges ago

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_presc = 0; m_count = 0; m_disp = 0;
            m_lap = 1'b0; m_ovf = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_deb[b] = 1'b1;
                m_pulse[b] = 1'b0;
                for (int j = 0; j < DEB + 2; j++) hist[b][j] = 1'b1;
            end
        end else begin
            bit sp, lc, tick, clr, flip;
            bit raw [2];
            raw[0] = sp_n;
            raw[1] = lc_n;
            sp   = m_pulse[0];
            lc   = m_pulse[1] && !sp;
            tick = (m_mode == 1) && (m_presc == CLK_DIV - 1);
            if (!m_lap) m_disp = m_count;
            if (m_mode == 1) m_presc = (m_presc + 1) % CLK_DIV;
            if (tick) begin
                m_count = m_count + 1;
                if (m_count == MODULUS) begin
                    m_count = 0;
                    m_ovf   = 1'b1;
                end
            end
            clr = 1'b0;
            if (sp) begin
                m_mode = (m_mode == 1) ? 2 : 1;
            end else if (lc) begin
                if (m_mode == 1) m_lap = !m_lap;
                else begin
                    clr    = 1'b1;
                    m_mode = 0;
                end
            end
            if (clr) begin
                m_count = 0; m_presc = 0; m_lap = 1'b0; m_ovf = 1'b0;
            end
            // A level is accepted once the synchronised input (2 edges late)
            // has disagreed with it for DEB consecutive edges.
            for (int b = 0; b < 2; b++) begin
                for (int j = DEB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = raw[b];
                flip = 1'b1;
                for (int j = 2; j < DEB + 2; j++) begin
                    if (hist[b][j] == m_deb[b]) flip = 1'b0;
                end
                m_pulse[b] = 1'b0;
                if (flip) begin
                    m_deb[b]   = !m_deb[b];
                    m_pulse[b] = !m_deb[b];
                end
            end
        end
    end

    function automatic logic [6:0] seg_hi(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input int v);
        logic [27:0] h;
        h[6:0]   = ~seg_hi(v % 10);
        h[13:7]  = ~seg_hi((v / 10) % 10);
        h[20:14] = ~seg_hi((v / 100) % 10);
        h[27:21] = ~seg_hi((v / 1000) % 6);
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Advance n cycles, comparing every output with the model at each negedge
    task automatic step(input int n);
        logic [30:0] act, req;
        repeat (n) begin
            @(negedge clk);
            act = {hex, running, lap_hold, overflow};
            req = {exp_hex(m_disp), (m_mode == 1), m_lap, m_ovf};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL cycle t=%0t actual={hex,run,lap,ovf}=%h required=%h",
                         $time, act, req);
            end
        end
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) sp_n = 1'b0; else lc_n = 1'b0;
        step(hold);
        if (b == 0) sp_n = 1'b1; else lc_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        check("reset_hex", 32'(hex), 32'h8102040);
        check("reset_running", 32'(running), 32'd0);
        check("reset_lap", 32'(lap_hold), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(4);

        // 1: start, ten ticks later the display reads 00.10
        press(0, 5);
        step(107);
        check("t1_running", 32'(running), 32'd1);
        check("t1_digit1", 32'(hex[13:7]), 32'h79);
        check("t1_digit0", 32'(hex[6:0]), 32'h40);

        // 2: pause holds 00.11 for 50 cycles, then resume
        press(0, 5);
        step(50);
        check("t2_paused_hex", 32'(hex), 32'h8103CF9);
        check("t2_paused_run", 32'(running), 32'd0);
        press(0, 5);
        step(20);
        check("t2_resumed", 32'(running), 32'd1);

        // 3: lap freeze on, then off
        press(1, 5);
        step(30);
        check("t3_lap_on", 32'(lap_hold), 32'd1);
        check("t3_still_run", 32'(running), 32'd1);
        press(1, 5);
        step(20);
        check("t3_lap_off", 32'(lap_hold), 32'd0);

        // 4: pause then clear; then simultaneous presses in RUN
        press(0, 5);
        step(10);
        check("t4_paused", 32'(running), 32'd0);
        press(1, 5);
        step(10);
        check("t4_clear_hex", 32'(hex), 32'h8102040);
        check("t4_clear_ovf", 32'(overflow), 32'd0);
        press(0, 5);
        step(10);
        check("t4_run_again", 32'(running), 32'd1);
        sp_n = 1'b0;
        lc_n = 1'b0;
        step(5);
        sp_n = 1'b1;
        lc_n = 1'b1;
        step(10);
        check("t4_both_run", 32'(running), 32'd0);
        check("t4_both_lap", 32'(lap_hold), 32'd0);

        // 5: clear, run to 59.99, wrap to 00.00 with overflow
        press(1, 5);
        step(10);
        press(0, 5);
        for (int i = 0; i < 61000 && m_disp != MODULUS - 1; i++) step(1);
        check("t5_max_hex", 32'(hex), 32'h2440810);
        check("t5_max_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 20 && overflow !== 1'b1; i++) step(1);
        check("t5_ovf_set", 32'(overflow), 32'd1);
        step(1);
        check("t5_wrap_hex", 32'(hex), 32'h8102040);
        check("t5_wrap_run", 32'(running), 32'd1);
        sp_n = 1'b0;
        step(1);
        sp_n = 1'b1;
        step(10);
        check("t5_glitch_run", 32'(running), 32'd1);

        // 6: async reset during RUN with lap held
        press(1, 5);
        step(10);
        check("t6_lap_on", 32'(lap_hold), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_hex", 32'(hex), 32'h8102040);
        check("t6_rst_run", 32'(running), 32'd0);
        check("t6_rst_lap", 32'(lap_hold), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(30);
        check("t6_after_hex", 32'(hex), 32'h8102040);
        check("t6_after_run", 32'(running), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
